// File: rtl/cache_evict_fill.sv
// cache_evict_fill: victim writeback plus line fill FSM for one cache set miss.
// Defining EVICT_PERF_COUNTER_EN adds a 32-bit completed-writeback counter.
module cache_evict_fill #(
  parameter int NUMWAYS = 4,
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss,
  input  logic [NUMWAYS-1:0] victim_way,
  input  logic               victim_dirty,
  input  logic [LINELEN-1:0] victim_line,
  output logic               bus_req,
  output logic               bus_write,
  output logic [BEATLEN-1:0] bus_wdata,
  input  logic               bus_ack,
  input  logic [BEATLEN-1:0] bus_rdata,
  output logic [NUMWAYS-1:0] line_write_en,
  output logic [LINELEN-1:0] fill_line,
  output logic               set_valid,
  output logic               clear_dirty,
  output logic               stall,
  output logic [31:0]        writeback_count
);
  localparam int BEATS = LINELEN / BEATLEN;
  localparam int CW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, WB, FILL, COMMIT} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [NUMWAYS-1:0] way;
  logic               ack, last, wb_done;
  // an ack only counts while a beat is actually being requested
  assign ack = bus_req & bus_ack;
  assign last = cnt == CW'(BEATS - 1);
  assign wb_done = state == WB && ack && last;
  assign bus_wdata = victim_line[cnt*BEATLEN +: BEATLEN];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      way <= '0;
      fill_line <= '0;
      bus_req <= 1'b0;
      bus_write <= 1'b0;
      line_write_en <= '0;
      set_valid <= 1'b0;
      clear_dirty <= 1'b0;
      stall <= 1'b0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          way <= victim_way;
          cnt <= '0;
          state <= victim_dirty ? WB : FILL;
          bus_req <= 1'b1;
          bus_write <= victim_dirty;
          stall <= 1'b1;
        end
        WB: if (ack) begin
          cnt <= cnt + 1'b1;
          state <= last ? FILL : WB;
          bus_write <= !last;
        end
        FILL: if (ack) begin
          fill_line[cnt*BEATLEN +: BEATLEN] <= bus_rdata;
          cnt <= cnt + 1'b1;
          state <= last ? COMMIT : FILL;
          bus_req <= !last;
          line_write_en <= last ? way : '0;
          set_valid <= last;
          clear_dirty <= last;
        end
        COMMIT: begin
          state <= IDLE;
          line_write_en <= '0;
          set_valid <= 1'b0;
          clear_dirty <= 1'b0;
          stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef EVICT_PERF_COUNTER_EN
  logic [31:0] wb_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) wb_cnt <= '0;
    else if (wb_done) wb_cnt <= wb_cnt + 32'd1;
  assign writeback_count = wb_cnt;
`else
  assign writeback_count = '0;
`endif
endmodule

// File: tb/tb_cache_evict_fill.sv
// tb_cache_evict_fill: randomized scoreboard bench for cache_evict_fill.
module tb_cache_evict_fill;
  localparam int NW = 4, LL = 256, BL = 64, NB = LL / BL;
  logic clk = 0, reset = 1, miss = 0, victim_dirty = 0, bus_ack = 0;
  logic [NW-1:0] victim_way = '0;
  logic [LL-1:0] victim_line = '0;
  logic [BL-1:0] bus_rdata = '0;
  logic bus_req, bus_write, set_valid, clear_dirty, stall;
  logic [BL-1:0] bus_wdata;
  logic [NW-1:0] line_write_en;
  logic [LL-1:0] fill_line;
  logic [31:0] writeback_count;
  typedef struct {logic [NW-1:0] way; logic [LL-1:0] line; logic [31:0] wbc; int cyc;} commit_t;
  logic [BL-1:0] wb_exp[$];
  commit_t cm_exp[$];
  commit_t mon_e;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] exp_wbc = 0;

  cache_evict_fill #(.NUMWAYS(NW), .LINELEN(LL), .BEATLEN(BL)) dut (
    .clk(clk), .reset(reset), .miss(miss), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_line(victim_line), .bus_req(bus_req),
    .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .line_write_en(line_write_en), .fill_line(fill_line),
    .set_valid(set_valid), .clear_dirty(clear_dirty), .stall(stall),
    .writeback_count(writeback_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [LL-1:0] act, input logic [LL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  // monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) if (!reset) begin
    if (bus_req) chk("stall_with_req", stall, 1);
    if (bus_req && bus_write && bus_ack) begin
      if (wb_exp.size() == 0) fail("wb_unexpected");
      else chk("wb_data", bus_wdata, wb_exp.pop_front());
    end
    if (line_write_en != 0) begin
      if (cm_exp.size() == 0) fail("commit_unexpected");
      else begin
        mon_e = cm_exp.pop_front();
        chk("commit_way", line_write_en, mon_e.way);
        chk("fill_line", fill_line, mon_e.line);
        chk("set_valid", set_valid, 1);
        chk("clear_dirty", clear_dirty, 1);
        chk("commit_stall", stall, 1);
        chk("wb_count", writeback_count, mon_e.wbc);
        if (mon_e.cyc >= 0) chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic reset_checks(input string n);
    chk({n, "_stall"}, stall, 0);
    chk({n, "_bus_req"}, bus_req, 0);
    chk({n, "_lwe"}, line_write_en, 0);
    chk({n, "_set_valid"}, set_valid, 0);
    chk({n, "_clear_dirty"}, clear_dirty, 0);
    chk({n, "_fill_line"}, fill_line, 0);
    chk({n, "_wb_count"}, writeback_count, 0);
  endtask

  task automatic idle_gap(input int n);
    miss = 0;
    for (int i = 0; i < n; i++) begin
      bus_ack = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // one replacement: model the expected writeback beats and committed line, then act as the bus
  task automatic op(input bit dirty, input int pct, input bit hold, input int abort_k);
    logic [BL-1:0] rb[NB];
    logic [LL-1:0] line, fl;
    logic [NW-1:0] way;
    commit_t c;
    int ridx, k;
    bit rd;
    k = 0;
    while ((stall || bus_req) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) fail("idle_timeout");
    way = NW'(1) << $urandom_range(NW - 1);
    for (int i = 0; i < LL / 32; i++) line[i*32 +: 32] = $urandom;
    for (int i = 0; i < NB; i++) begin
      rb[i] = {$urandom, $urandom};
      fl[i*BL +: BL] = rb[i];
    end
    miss = 1;
    victim_way = way;
    victim_dirty = dirty;
    victim_line = line;
    bus_ack = 1'($urandom);
    if (dirty) begin
      for (int i = 0; i < NB; i++) wb_exp.push_back(line[i*BL +: BL]);
`ifdef EVICT_PERF_COUNTER_EN
      exp_wbc++;
`endif
    end
    c.way = way;
    c.line = fl;
    c.wbc = exp_wbc;
    c.cyc = pct == 100 ? cyc + 1 + (dirty ? 2 * NB : NB) : -1;
    cm_exp.push_back(c);
    @(posedge clk);
    #1;
    ridx = 0;
    k = 0;
    while (stall && k < 1000) begin
      if (k == abort_k) begin
        reset = 1;
        miss = 0;
        wb_exp.delete();
        cm_exp.delete();
        exp_wbc = 0;
        @(negedge clk);
        reset_checks("abort");
        @(posedge clk);
        #1;
        reset = 0;
        return;
      end
      miss = hold ? 1'b1 : 1'($urandom);
      victim_way = NW'($urandom);
      victim_dirty = 1'($urandom);
      bus_ack = bus_req ? ($urandom_range(99) < pct) : 1'($urandom);
      bus_rdata = (bus_req && !bus_write && ridx < NB) ? rb[ridx] : {$urandom, $urandom};
      rd = bus_req && !bus_write && bus_ack;
      @(posedge clk);
      if (rd) ridx++;
      #1;
      k++;
    end
    if (k >= 1000) fail("op_timeout");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1;
    reset = 0;
    op(0, 100, 0, -1);
    op(1, 100, 0, -1);
    op(0, 25, 0, -1);
    op(1, 25, 0, -1);
    op(0, 100, 0, 2);
    idle_gap(3);
    op(1, 100, 1, -1);
    op(0, 100, 1, -1);
    op(1, 100, 0, -1);
    for (int i = 0; i < 40; i++) begin
      op(1'($urandom), $urandom_range(20, 100), 1'($urandom), -1);
      if ($urandom_range(3) == 0) idle_gap($urandom_range(1, 4));
    end
    idle_gap(10);
    if (wb_exp.size() != 0) fail("wb_queue_leftover");
    if (cm_exp.size() != 0) fail("commit_queue_leftover");
    chk("final_wb_count", writeback_count, exp_wbc);
    chk("final_stall", stall, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_evict_fill.md
CACHE_EVICT_FILL -- requirements
Module: cacheevictfill

Interface
REQ-001 Parameter NUMWAYS, default 4, number of cache ways; SHALL be a power of two, 2 to 16.
REQ-002 Parameter LINELEN, default 256, cache line width in bits.
REQ-003 Parameter BEATLEN, default 64, bus beat width in bits; SHALL divide LINELEN, BEATS = LINELEN/BEATLEN, at least 2.
REQ-004 clk  in  1  sole clock; every state element SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous and active-high.
REQ-006 Miss  in  1  request to replace a line; sampled only in IDLE.
REQ-007 VictimWay  in  NUMWAYS  one-hot way chosen by the replacement policy; captured with Miss.
REQ-008 VictimDirty  in  1  dirty bit of the victim line; captured with Miss.
REQ-009 VictimLine  in  LINELEN  victim line data; stable for the whole WB state.
REQ-010 BusReq  out  1  a bus beat is requested.
REQ-011 BusWrite  out  1  1 = writeback beat, 0 = fetch beat.
REQ-012 BusWData  out  BEATLEN  writeback beat data.
REQ-013 BusAck  in  1  bus completes the current beat this cycle.
REQ-014 BusRData  in  BEATLEN  fetch beat data; valid when BusAck=1 in FILL.
REQ-015 LineWriteEn  out  NUMWAYS  one-hot data-array write strobe for the captured way.
REQ-016 FillLine  out  LINELEN  assembled fetched line.
REQ-017 SetValid, ClearDirty  out  1 each  tag-array updates, asserted with LineWriteEn.
REQ-018 Stall  out  1  pipeline stall while the block is not in IDLE.
REQ-019 WritebackCount  out  32  number of completed writebacks (see Configuration).

Function
REQ-020 The FSM SHALL have states IDLE, WB, FILL and COMMIT.
REQ-021 IDLE: when Miss=1, the block SHALL capture VictimWay and VictimDirty, then go to WB if VictimDirty=1, else to FILL.
REQ-022 The beat counter SHALL be log2(BEATS) bits; it SHALL clear on entry to WB and to FILL, increment on each BusAck, and wrap to 0 after BEATS-1.
REQ-023 WB: BusReq=1 and BusWrite=1; BusWData SHALL equal beat[count] of VictimLine, with beat 0 in the LSBs.
REQ-024 WB: BusAck at count BEATS-1 SHALL move the FSM to FILL.
REQ-025 FILL: BusReq=1 and BusWrite=0; each BusAck SHALL store BusRData into FillLine beat[count].
REQ-026 FILL: BusAck at count BEATS-1 SHALL move the FSM to COMMIT.
REQ-027 COMMIT: for exactly one cycle, LineWriteEn SHALL equal the captured way, SetValid=1 and ClearDirty=1; the FSM SHALL then return to IDLE.
REQ-028 Stall SHALL be 1 in WB, FILL and COMMIT, and 0 in IDLE.
REQ-029 BusReq SHALL hold high until BusAck; BusAck with BusReq=0 SHALL be ignored.
REQ-030 Miss outside IDLE SHALL be ignored; the captured way SHALL not change mid-operation.
REQ-031 A Miss in the cycle after COMMIT SHALL be accepted normally (back-to-back operation).
REQ-032 Minimum latency from Miss to COMMIT: BEATS+1 cycles when clean, 2*BEATS+1 cycles when dirty.

Reset
REQ-033 Reset SHALL force state IDLE, counter 0, captured way 0, FillLine 0 and WritebackCount 0.
REQ-034 Reset SHALL drive BusReq, LineWriteEn, SetValid, ClearDirty and Stall to 0.
REQ-035 Reset asserted mid-operation SHALL abandon the transfer immediately, with no COMMIT strobe.

Configuration
REQ-036 Macro EVICT_PERF_COUNTER_EN: when defined, WritebackCount SHALL increment by 1 on the WB-to-FILL transition and wrap at 2^32.
REQ-037 When EVICT_PERF_COUNTER_EN is undefined, WritebackCount SHALL be tied to 0 and no counter flop SHALL exist.

Verification (NUMWAYS=4, BEATS=4)
REQ-038 Clean miss: Miss, VictimWay=0100, VictimDirty=0, BusAck every cycle -> 4 read beats, COMMIT in cycle 5 with LineWriteEn=0100, FillLine equal to the concatenated beats.
REQ-039 Dirty miss: VictimDirty=1, VictimLine=0x33..22..11..00 -> BusWData 0x00.., 0x11.., 0x22.., 0x33.. in that order, then 4 read beats, WritebackCount=1.
REQ-040 Bus wait states: BusAck low for 3 cycles per beat -> BusReq held high, counter stable, FillLine correct.
REQ-041 Reset asserted during FILL beat 2 -> next cycle in IDLE, Stall=0, no LineWriteEn pulse.
REQ-042 Miss held high through an operation -> exactly one COMMIT, then a new capture in the following IDLE cycle.
REQ-043 Build without EVICT_PERF_COUNTER_EN, run the dirty miss -> WritebackCount stays 0.
